// File: rtl/shift_exec_pipe.sv
// Two-stage shift/rotate execute pipe: S1 latches the operand, S2 latches the result; 2-cycle latency, 1 op/cycle.
// Valid/ready on both sides; out_ready low stalls S2 then S1, and in_ready drops once both are full.
module shift_exec_pipe #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [OPERAND_WIDTH-1:0] in_data,
  input  logic [SHAMT_WIDTH-1:0]   in_shamt,
  input  logic [2:0]               in_rd,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_data,
  output logic [2:0]               out_rd,
  output logic                     out_err,
  output logic                     busy
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic                     s1_valid;
  logic [2:0]               s1_op;
  logic [OPERAND_WIDTH-1:0] s1_data;
  logic [SHAMT_WIDTH-1:0]   s1_shamt;
  logic [2:0]               s1_rd;

  logic                     s2_valid;
  logic [OPERAND_WIDTH-1:0] s2_data;
  logic [2:0]               s2_rd;
  logic                     s2_err;

  logic s2_load;
  logic accept;

  // in_ready never looks at in_valid, so upstream can't form a combinational loop through it.
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !flush && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  logic op_legal;
  logic go_left;
  logic rotate;
  logic arith;

  always_comb begin
    op_legal = (s1_op <= OP_ROR);
    go_left  = (s1_op == OP_SLL) || (s1_op == OP_ROL);
    rotate   = (s1_op == OP_ROL) || (s1_op == OP_ROR);
    arith    = (s1_op == OP_SRA);
  end

  // Log shifter: stage k moves by 2**k when shamt[k] is set; the last stage moves by half the width.
  for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [OPERAND_WIDTH-1:0] d;
    logic [OPERAND_WIDTH-1:0] q;
    logic [OPERAND_WIDTH-1:0] shl;
    logic [OPERAND_WIDTH-1:0] shr;
    logic [SH-1:0]            lo_fill;
    logic [SH-1:0]            hi_fill;

    if (k == 0) begin : g_first
      assign d = s1_data;
    end else begin : g_next
      assign d = g_stage[k-1].q;
    end

    assign lo_fill = rotate ? d[OPERAND_WIDTH-1 -: SH] : '0;
    assign hi_fill = rotate ? d[SH-1:0] : (arith ? {SH{s1_data[OPERAND_WIDTH-1]}} : '0);
    assign shl     = {d[OPERAND_WIDTH-SH-1:0], lo_fill};
    assign shr     = {hi_fill, d[OPERAND_WIDTH-1:SH]};
    assign q       = !s1_shamt[k] ? d : (go_left ? shl : shr);
  end

  logic [OPERAND_WIDTH-1:0] result;
  assign result = op_legal ? g_stage[SHAMT_WIDTH-1].q : s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_load);
      s2_valid <= s2_load || (s2_valid && !out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op    <= '0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_rd    <= '0;
    end else if (accept) begin
      s1_op    <= in_op;
      s1_data  <= in_data;
      s1_shamt <= in_shamt;
      s1_rd    <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_data <= '0;
      s2_rd   <= '0;
      s2_err  <= 1'b0;
    end else if (s2_load && !flush) begin
      s2_data <= result;
      s2_rd   <= s1_rd;
      s2_err  <= !op_legal;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_rd    = s2_rd;
  assign out_err   = s2_err;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Bench for shift_exec_pipe: directed literal cases plus random traffic against a queue-based reference model.
module tb_shift_exec_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [2:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_rd;
  logic        out_err;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  shift_exec_pipe #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .in_rd(in_rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain shift operators on the operand.
  function automatic logic [15:0] ref_shift(input logic [2:0] op, input logic [15:0] d, input logic [3:0] s);
    logic signed [15:0] sd;
    logic [31:0] dd;
    logic [31:0] rl;
    logic [31:0] rr;
    sd = d;
    dd = {d, d};
    rl = dd << s;
    rr = dd >> s;
    case (op)
      3'd0:    return d << s;
      3'd1:    return d >> s;
      3'd2:    return sd >>> s;
      3'd3:    return rl[31:16];
      3'd4:    return rr[15:0];
      default: return d;
    endcase
  endfunction

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        err;
    int          age;
  } item_t;

  item_t q[$];

  // Ops in flight are exactly the queue; the head is visible once it has spent an edge in S1, or when both stages are full.
  function automatic logic m_valid();
    if (q.size() == 0) return 1'b0;
    if (q.size() >= 2) return 1'b1;
    return q[0].age >= 1;
  endfunction

  function automatic logic m_ready();
    return !flush && (q.size() < 2 || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      logic  acc;
      logic  pop;
      item_t it;
      acc = in_valid && m_ready();
      pop = m_valid() && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) begin
          it.data = ref_shift(in_op, in_data, in_shamt);
          it.rd   = in_rd;
          it.err  = (in_op > 3'd4);
          it.age  = 0;
          q.push_back(it);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid()});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
    if (q.size() > 2) chk("queue_depth", q.size(), 2);
    if (m_valid()) begin
      chk("out_data", {16'd0, out_data}, {16'd0, q[0].data});
      chk("out_rd", {29'd0, out_rd}, {29'd0, q[0].rd});
      chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single op into an empty pipe: result must be on the outputs one edge after acceptance.
  task automatic do_op(input string name, input logic [2:0] op, input logic [15:0] d, input logic [3:0] s,
                       input logic [15:0] exp_d, input logic exp_e);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_shamt  = s;
    in_rd     = 3'd5;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_not_yet"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, {16'd0, out_data}, {16'd0, exp_d});
    chk({name, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
    step();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_data   = 16'd0;
    in_shamt  = 4'd0;
    in_rd     = 3'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    do_op("sra_8000_4", 3'd2, 16'h8000, 4'd4, 16'hF800, 1'b0);
    do_op("ror_0001_1", 3'd4, 16'h0001, 4'd1, 16'h8000, 1'b0);
    do_op("rol_8001_4", 3'd3, 16'h8001, 4'd4, 16'h0018, 1'b0);
    do_op("sll_ffff_15", 3'd0, 16'hFFFF, 4'd15, 16'h8000, 1'b0);
    do_op("srl_8000_15", 3'd1, 16'h8000, 4'd15, 16'h0001, 1'b0);
    do_op("illegal_110", 3'd6, 16'h1234, 4'd3, 16'h1234, 1'b1);
    do_op("sra_abcd_0", 3'd2, 16'hABCD, 4'd0, 16'hABCD, 1'b0);

    // Backpressure: three back-to-back ops with out_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_data   = 16'h0001;
    in_shamt  = 4'd1;
    in_rd     = 3'd1;
    step();
    in_rd = 3'd2;
    chk("bp_ready_2nd", {31'd0, in_ready}, 32'd1);
    step();
    in_rd = 3'd3;
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    repeat (2) step();
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_rd", {29'd0, out_rd}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_drain_rd2", {29'd0, out_rd}, 32'd2);
    step();
    chk("bp_drain_rd3", {29'd0, out_rd}, 32'd3);
    step();
    chk("bp_drained", {31'd0, busy}, 32'd0);

    // Flush with two ops in flight and a third offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rd     = 3'd4;
    step();
    in_rd = 3'd6;
    step();
    flush = 1'b1;
    in_rd = 3'd7;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    step();

    // Asynchronous reset between edges with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd2;
    in_data   = 16'hF0F0;
    in_shamt  = 4'd2;
    in_rd     = 3'd1;
    step();
    in_rd = 3'd2;
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {16'd0, out_data}, 32'd0);
    chk("arst_out_rd", {29'd0, out_rd}, 32'd0);
    chk("arst_out_err", {31'd0, out_err}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    step();
    do_op("post_rst_srl", 3'd1, 16'hF000, 4'd4, 16'h0F00, 1'b0);

    // Random traffic; the reference model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      in_op     = 3'($urandom_range(0, 7));
      in_data   = 16'($urandom);
      in_shamt  = 4'($urandom_range(0, 15));
      in_rd     = 3'($urandom_range(0, 7));
      step();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
